// File: rtl/commit_trace_serializer.sv
// Buffers per-cycle dual-issue commit bundles and emits them one event at a time over valid/ready.
// Optional macro TRACE_CYCLE_EN adds a 32-bit cycle stamp per bundle driven on ev_cycle.
module commit_trace_serializer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_reg_we,
  input  logic        b_reg_we,
  input  logic [4:0]  a_reg_waddr,
  input  logic [4:0]  b_reg_waddr,
  input  logic [31:0] a_reg_wdata,
  input  logic [31:0] b_reg_wdata,
  input  logic        a_hilo_we,
  input  logic        b_hilo_we,
  input  logic [63:0] a_hilo,
  input  logic [63:0] b_hilo,
  input  logic        a_mem_we,
  input  logic        b_mem_we,
  input  logic [15:0] a_mem_addr,
  input  logic [15:0] b_mem_addr,
  input  logic [31:0] a_mem_wdata,
  input  logic [31:0] b_mem_wdata,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_kind,
  output logic        ev_slot,
  output logic [15:0] ev_addr,
  output logic [63:0] ev_data,
  output logic [31:0] ev_cycle,
  output logic        overflow
);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned MW        = 6;
  localparam int unsigned HILO_LSB  = 0;
  localparam int unsigned WDATA_LSB = 64;
  localparam int unsigned WADDR_LSB = 96;
  localparam int unsigned MDATA_LSB = 101;
  localparam int unsigned MADDR_LSB = 133;
  localparam int unsigned SW        = 149;

  localparam logic [1:0] K_REG  = 2'd0;
  localparam logic [1:0] K_HILO = 2'd1;
  localparam logic [1:0] K_MEM  = 2'd2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [MW-1:0]   r_mask [DEPTH];
  logic [2*SW-1:0] r_pl   [DEPTH];
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [0:0]      r_state, w_state_nxt;
  logic [MW-1:0]   r_rem, w_rem_nxt, w_mask, w_rem_clr, w_sel_mask;
  logic            r_overflow, r_ev_valid, w_valid_nxt;
  logic [1:0]      r_ev_kind, w_sel_kind;
  logic            r_ev_slot, w_sel_slot;
  logic [15:0]     r_ev_addr, w_sel_addr;
  logic [63:0]     r_ev_data, w_sel_data;
  logic            w_push, w_pop, w_load, w_full, w_empty, w_have_next, w_wr_en;
  logic [AW-1:0]   w_rd_idx, w_rd_idx_n, w_sel_idx;
  logic [PW-1:0]   w_count;
  logic [2*SW-1:0] w_pl_in;
  logic [SW-1:0]   w_slot_pl;
  logic [2:0]      w_bit;
  logic            w_unused_addr_lsb;

  // Mask bit order is the emission order: memA, regA, hiloA, memB, regB, hiloB.
  assign w_mask = {b_hilo_we, b_reg_we & (b_reg_waddr != 5'd0), b_mem_we,
                   a_hilo_we, a_reg_we & (a_reg_waddr != 5'd0), a_mem_we};
  assign w_push = |w_mask;
  assign w_pl_in = {b_mem_addr[15:2], 2'b00, b_mem_wdata, b_reg_waddr, b_reg_wdata, b_hilo,
                    a_mem_addr[15:2], 2'b00, a_mem_wdata, a_reg_waddr, a_reg_wdata, a_hilo};
  assign w_unused_addr_lsb = ^{a_mem_addr[1:0], b_mem_addr[1:0]};

  assign w_rd_idx    = r_rptr[AW-1:0];
  assign w_rd_idx_n  = w_rd_idx + AW'(1);
  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_have_next = (w_count > PW'(1));
  assign w_rem_clr   = r_rem & (r_rem - MW'(1));
  assign w_wr_en     = ~rst & w_push & (~w_full | w_pop);

  // Unpacker: pick the next event to present and decide when the head bundle retires.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_valid_nxt = r_ev_valid;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_sel_idx   = w_rd_idx;
    w_sel_mask  = r_mask[w_rd_idx];
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_rem_nxt   = r_mask[w_rd_idx];
          w_valid_nxt = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end
      S_EMIT: begin
        if (ev_ready) begin
          if (w_rem_clr != '0) begin
            w_load     = 1'b1;
            w_sel_mask = w_rem_clr;
            w_rem_nxt  = w_rem_clr;
          end else begin
            w_pop = 1'b1;
            if (w_have_next) begin
              w_load     = 1'b1;
              w_sel_idx  = w_rd_idx_n;
              w_sel_mask = r_mask[w_rd_idx_n];
              w_rem_nxt  = r_mask[w_rd_idx_n];
            end else begin
              w_rem_nxt   = '0;
              w_valid_nxt = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decode the lowest set mask bit into the outgoing event fields.
  always_comb begin
    w_bit = 3'd0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (w_sel_mask[i]) w_bit = 3'(i);
    end
    w_sel_slot = (w_bit >= 3'd3);
    w_slot_pl  = w_sel_slot ? r_pl[w_sel_idx][2*SW-1:SW] : r_pl[w_sel_idx][SW-1:0];
    w_sel_kind = K_REG;
    w_sel_addr = '0;
    w_sel_data = '0;
    case (w_bit)
      3'd0, 3'd3: begin
        w_sel_kind = K_MEM;
        w_sel_addr = w_slot_pl[MADDR_LSB+15:MADDR_LSB];
        w_sel_data = {32'd0, w_slot_pl[MDATA_LSB+31:MDATA_LSB]};
      end
      3'd1, 3'd4: begin
        w_sel_kind = K_REG;
        w_sel_addr = {11'd0, w_slot_pl[WADDR_LSB+4:WADDR_LSB]};
        w_sel_data = {32'd0, w_slot_pl[WDATA_LSB+31:WDATA_LSB]};
      end
      default: begin
        w_sel_kind = K_HILO;
        w_sel_data = w_slot_pl[HILO_LSB+63:HILO_LSB];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_ev_valid <= 1'b0;
      r_ev_kind  <= '0;
      r_ev_slot  <= 1'b0;
      r_ev_addr  <= '0;
      r_ev_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_ev_valid <= w_valid_nxt;
      if (w_load) begin
        r_ev_kind <= w_sel_kind;
        r_ev_slot <= w_sel_slot;
        r_ev_addr <= w_sel_addr;
        r_ev_data <= w_sel_data;
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      if (w_wr_en) r_wptr <= r_wptr + PW'(1);
      if (w_push && !w_wr_en) r_overflow <= 1'b1;
    end
  end

  // Bundle storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mask[r_wptr[AW-1:0]] <= w_mask;
      r_pl[r_wptr[AW-1:0]]   <= w_pl_in;
    end
  end

`ifdef TRACE_CYCLE_EN
  logic [31:0] r_cycle, r_ev_cycle;
  logic [31:0] r_cyc_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle    <= '0;
      r_ev_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_load) r_ev_cycle <= r_cyc_mem[w_sel_idx];
    end
  end

  // A bundle is stamped with the count value this edge produces.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_cyc_mem[r_wptr[AW-1:0]] <= r_cycle + 32'd1;
  end

  assign ev_cycle = r_ev_cycle;
`else
  assign ev_cycle = 32'd0;
`endif

  assign ev_valid = r_ev_valid;
  assign ev_kind  = r_ev_kind;
  assign ev_slot  = r_ev_slot;
  assign ev_addr  = r_ev_addr;
  assign ev_data  = r_ev_data;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Scoreboard bench for commit_trace_serializer (DEPTH = 4); expected events are queued at drive time.
module tb_commit_trace_serializer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic a_reg_we, b_reg_we, a_hilo_we, b_hilo_we, a_mem_we, b_mem_we;
  logic [4:0]  a_reg_waddr, b_reg_waddr;
  logic [31:0] a_reg_wdata, b_reg_wdata, a_mem_wdata, b_mem_wdata;
  logic [63:0] a_hilo, b_hilo;
  logic [15:0] a_mem_addr, b_mem_addr;
  logic        ev_valid, ev_ready, ev_slot, overflow;
  logic [1:0]  ev_kind;
  logic [15:0] ev_addr;
  logic [63:0] ev_data;
  logic [31:0] ev_cycle;

  typedef struct packed {
    logic [1:0]  kind;
    logic        slot;
    logic [15:0] addr;
    logic [63:0] data;
    logic [31:0] cyc;
  } ev_t;

  ev_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] tb_cyc;

  commit_trace_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_reg_we(a_reg_we), .b_reg_we(b_reg_we),
    .a_reg_waddr(a_reg_waddr), .b_reg_waddr(b_reg_waddr),
    .a_reg_wdata(a_reg_wdata), .b_reg_wdata(b_reg_wdata),
    .a_hilo_we(a_hilo_we), .b_hilo_we(b_hilo_we),
    .a_hilo(a_hilo), .b_hilo(b_hilo),
    .a_mem_we(a_mem_we), .b_mem_we(b_mem_we),
    .a_mem_addr(a_mem_addr), .b_mem_addr(b_mem_addr),
    .a_mem_wdata(a_mem_wdata), .b_mem_wdata(b_mem_wdata),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_kind(ev_kind), .ev_slot(ev_slot), .ev_addr(ev_addr),
    .ev_data(ev_data), .ev_cycle(ev_cycle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference cycle counter.
  always @(posedge clk) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic s, input logic [15:0] a,
                             input logic [63:0] d, input logic [31:0] c);
    ev_t e;
    e.kind = k; e.slot = s; e.addr = a; e.data = d; e.cyc = c;
    return e;
  endfunction

  // Compare the presented event against the scoreboard head; retire it on handshake.
  always @(negedge clk) begin : mon
    ev_t e;
    if (rst !== 1'b1 && ev_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_event", 64'(ev_valid), 64'd0);
      end else begin
        e = q[0];
        check("ev_kind",  64'(ev_kind),  64'(e.kind));
        check("ev_slot",  64'(ev_slot),  64'(e.slot));
        check("ev_addr",  64'(ev_addr),  64'(e.addr));
        check("ev_data",  ev_data,       e.data);
        check("ev_cycle", 64'(ev_cycle), 64'(e.cyc));
        if (ev_ready === 1'b1) void'(q.pop_front());
      end
    end
  end

  task automatic clear_in();
    a_reg_we = 0; b_reg_we = 0; a_hilo_we = 0; b_hilo_we = 0; a_mem_we = 0; b_mem_we = 0;
    a_reg_waddr = '0; b_reg_waddr = '0; a_reg_wdata = '0; b_reg_wdata = '0;
    a_hilo = '0; b_hilo = '0; a_mem_addr = '0; b_mem_addr = '0;
    a_mem_wdata = '0; b_mem_wdata = '0;
  endtask

  // Queue the events the current inputs should produce, then clock them in.
  task automatic push_bundle(input bit keep);
    logic [31:0] st;
`ifdef TRACE_CYCLE_EN
    st = tb_cyc + 32'd1;
`else
    st = 32'd0;
`endif
    if (keep) begin
      if (a_mem_we) q.push_back(mk(2'd2, 1'b0, {a_mem_addr[15:2], 2'b00}, {32'd0, a_mem_wdata}, st));
      if (a_reg_we && a_reg_waddr != 0) q.push_back(mk(2'd0, 1'b0, {11'd0, a_reg_waddr}, {32'd0, a_reg_wdata}, st));
      if (a_hilo_we) q.push_back(mk(2'd1, 1'b0, 16'd0, a_hilo, st));
      if (b_mem_we) q.push_back(mk(2'd2, 1'b1, {b_mem_addr[15:2], 2'b00}, {32'd0, b_mem_wdata}, st));
      if (b_reg_we && b_reg_waddr != 0) q.push_back(mk(2'd0, 1'b1, {11'd0, b_reg_waddr}, {32'd0, b_reg_wdata}, st));
      if (b_hilo_we) q.push_back(mk(2'd1, 1'b1, 16'd0, b_hilo, st));
    end
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic drain(input bit rnd_ready);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      ev_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ev_ready = 1'b1;
    check("drain_left", 64'(q.size()), 64'd0);
    check("drain_idle", 64'(ev_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ev_ready = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid", 64'(ev_valid), 64'd0);
    check("rst_kind",  64'(ev_kind),  64'd0);
    check("rst_slot",  64'(ev_slot),  64'd0);
    check("rst_addr",  64'(ev_addr),  64'd0);
    check("rst_data",  ev_data,       64'd0);
    check("rst_cycle", 64'(ev_cycle), 64'd0);
    check("rst_ovf",   64'(overflow), 64'd0);

    // Single REG event and its two-edge latency.
    ev_ready = 1'b1;
    a_reg_we = 1; a_reg_waddr = 5'd3; a_reg_wdata = 32'h1234;
    push_bundle(1);
    check("lat_capture_edge", 64'(ev_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_load_edge", 64'(ev_valid), 64'd1);
    drain(0);

    // All six strobes: fixed order, one event per cycle.
    a_mem_we = 1; a_mem_addr = 16'h1007; a_mem_wdata = 32'hA1A1_0001;
    a_reg_we = 1; a_reg_waddr = 5'd9;    a_reg_wdata = 32'hA2A2_0002;
    a_hilo_we = 1; a_hilo = 64'h1111_2222_3333_4444;
    b_mem_we = 1; b_mem_addr = 16'h2002; b_mem_wdata = 32'hB1B1_0003;
    b_reg_we = 1; b_reg_waddr = 5'd31;   b_reg_wdata = 32'hB2B2_0004;
    b_hilo_we = 1; b_hilo = 64'h5555_6666_7777_8888;
    push_bundle(1);
    @(posedge clk); #1;
    check("full_first_valid", 64'(ev_valid), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("full_six_cycles", 64'(q.size()), 64'd0);
    check("full_then_idle", 64'(ev_valid), 64'd0);

    // $0 writes are not events.
    a_reg_we = 1; a_reg_waddr = 5'd0; a_reg_wdata = 32'hDEAD;
    push_bundle(1);
    repeat (3) @(posedge clk);
    #1;
    check("zero_reg_none", 64'(ev_valid), 64'd0);
    a_reg_we = 1; a_reg_waddr = 5'd0; a_reg_wdata = 32'hDEAD;
    b_reg_we = 1; b_reg_waddr = 5'd5; b_reg_wdata = 32'h0000_BEEF;
    push_bundle(1);
    drain(0);

    // Backpressure: event held stable for 5 cycles, then taken on the first ready cycle.
    ev_ready = 1'b0;
    b_mem_we = 1; b_mem_addr = 16'h0ABF; b_mem_wdata = 32'hCAFE_F00D;
    push_bundle(1);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check("bp_still_pending", 64'(q.size()), 64'd1);
    check("bp_valid_held", 64'(ev_valid), 64'd1);
    ev_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_taken", 64'(q.size()), 64'd0);
    check("bp_idle", 64'(ev_valid), 64'd0);

    // Random bundles with random backpressure.
    for (int i = 0; i < 20; i++) begin
      a_mem_we = 1'($urandom_range(0, 1)); a_reg_we = 1'($urandom_range(0, 1));
      a_hilo_we = 1'($urandom_range(0, 1)); b_mem_we = 1'($urandom_range(0, 1));
      b_reg_we = 1'($urandom_range(0, 1)); b_hilo_we = 1'($urandom_range(0, 1));
      a_reg_waddr = 5'($urandom); b_reg_waddr = 5'($urandom);
      a_reg_wdata = $urandom; b_reg_wdata = $urandom;
      a_mem_addr = 16'($urandom); b_mem_addr = 16'($urandom);
      a_mem_wdata = $urandom; b_mem_wdata = $urandom;
      a_hilo = {$urandom, $urandom}; b_hilo = {$urandom, $urandom};
      push_bundle(1);
      drain(1);
    end

    // Back-to-back single-event bundles stream without bubbles.
    ev_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_hilo_we = 1; a_hilo = {$urandom, $urandom};
      push_bundle(1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("b2b_rate", 64'(q.size()), 64'd0);
    check("b2b_idle", 64'(ev_valid), 64'd0);

    // Push while full with a same-edge pop is accepted.
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_reg_we = 1; a_reg_waddr = 5'(i + 1); a_reg_wdata = 32'(i + 100);
      push_bundle(1);
    end
    ev_ready = 1'b1;
    b_reg_we = 1; b_reg_waddr = 5'd17; b_reg_wdata = 32'h5050;
    push_bundle(1);
    check("pushpop_no_ovf", 64'(overflow), 64'd0);
    drain(0);
    check("pushpop_no_ovf_end", 64'(overflow), 64'd0);

    // Overflow: fifth bundle into a full FIFO is dropped, flag is sticky.
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_reg_we = 1; a_reg_waddr = 5'(i + 1); a_reg_wdata = 32'(i);
      push_bundle(i < 4);
      if (i == 3) check("ovf_not_yet", 64'(overflow), 64'd0);
      if (i == 4) check("ovf_set", 64'(overflow), 64'd1);
    end
    drain(0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset with three bundles buffered; reset-cycle inputs are ignored.
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_hilo_we = 1; b_hilo = 64'(i + 7);
      push_bundle(1);
    end
    rst = 1'b1;
    a_reg_we = 1; a_reg_waddr = 5'd7; a_reg_wdata = 32'h7777;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_in();
    q.delete();
    check("midrst_valid", 64'(ev_valid), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    ev_ready = 1'b1;
    a_mem_we = 1; a_mem_addr = 16'h00F3; a_mem_wdata = 32'h0BAD_CAFE;
    push_bundle(1);
    drain(0);

    repeat (3) @(posedge clk);
    #1;
    check("end_queue_empty", 64'(q.size()), 64'd0);
    check("end_idle", 64'(ev_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
